// File: rtl/sc_stream_encoder.sv
// Unipolar stochastic-computing encoder: turns a probability numerator (0..64)
// into a 64-bit bitstream whose popcount equals the clamped value exactly.
module sc_stream_encoder #(
  parameter logic [5:0] SEED = 6'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [6:0]  in_value,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_stream,
  input  logic        out_ready
);

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [5:0] SEED_EFF = (SEED == 6'h00) ? 6'h01 : SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [5:0]  lfsr_q, lfsr_d;
  logic [6:0]  value_q, value_d;
  logic [63:0] stream_q, stream_d;
  logic [5:0]  rnd;
  logic        bit_w;

  function automatic logic [6:0] clamp_value(input logic [6:0] v);
    return (v > 7'd64) ? 7'd64 : v;
  endfunction

  // x^6 + x^5 + 1, maximal length (63 non-zero states).
  function automatic logic [5:0] lfsr_next(input logic [5:0] l);
    return {l[4:0], l[5] ^ l[4]};
  endfunction

  // Slot 0 compares against 0 and slots 1..63 walk every non-zero LFSR state
  // once, so the comparison thresholds cover 0..63 exactly one time each.
  always_comb begin
    rnd   = (count_q == 6'd0) ? 6'd0 : lfsr_q;
    bit_w = ({1'b0, rnd} < value_q);
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    lfsr_d   = lfsr_q;
    value_d  = value_q;
    stream_d = stream_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          value_d  = clamp_value(in_value);
          count_d  = 6'd0;
          lfsr_d   = SEED_EFF;
          stream_d = 64'h0;
          state_d  = GEN;
        end
      end
      GEN: begin
        stream_d[count_q] = bit_w;
        count_d = count_q + 6'd1;
        if (count_q != 6'd0) begin
          lfsr_d = lfsr_next(lfsr_q);
        end
        if (count_q == 6'd63) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= 6'd0;
      lfsr_q   <= SEED_EFF;
      value_q  <= 7'd0;
      stream_q <= 64'h0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      lfsr_q   <= lfsr_d;
      value_q  <= value_d;
      stream_q <= stream_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == HOLD);
  assign out_stream = stream_q;

endmodule

// File: tb/tb_sc_stream_encoder.sv
// Directed bench for sc_stream_encoder: three instances (SEED 1, 2A, 0) share
// stimulus; each scenario task checks its own expectations.
module tb_sc_stream_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [6:0]  in_value;
  logic        out_ready;
  logic        ir [3];
  logic        ov [3];
  logic [63:0] st [3];
  logic [5:0]  sd [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_stream_encoder #(.SEED(6'h01)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_stream(st[0]), .out_ready(out_ready));
  sc_stream_encoder #(.SEED(6'h2A)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_stream(st[1]), .out_ready(out_ready));
  sc_stream_encoder #(.SEED(6'h00)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
    .in_ready(ir[2]), .out_valid(ov[2]), .out_stream(st[2]), .out_ready(out_ready));

  function automatic logic [63:0] model_stream(input logic [6:0] v, input logic [5:0] seed);
    logic [63:0] s;
    logic [5:0]  l;
    logic [5:0]  r;
    logic [6:0]  cv;
    cv = (v > 7'd64) ? 7'd64 : v;
    l  = (seed == 6'h00) ? 6'h01 : seed;
    s  = 64'h0;
    for (int k = 0; k < 64; k++) begin
      r    = (k == 0) ? 6'd0 : l;
      s[k] = ({1'b0, r} < cv);
      if (k >= 1) l = {l[4:0], l[5] ^ l[4]};
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operand from IDLE and waits (bounded) for out_valid on dut0.
  task automatic run_to_hold(input logic [6:0] v, output int lat, output logic ir_seen);
    in_value = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    ir_seen = 1'b0;
    while (ov[0] !== 1'b1 && lat < 200) begin
      if (ir[0] !== 1'b0) ir_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_value = 7'd40; out_ready = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || st[d] !== 64'h0) begin
          errors++;
          $display("FAIL reset_idle dut%0d cyc%0d: in_ready=%b out_valid=%b stream=%h want 1 0 0",
                   d, c, ir[d], ov[d], st[d]);
        end
      end
    end
  endtask

  task automatic test_extremes();
    logic [6:0]  vals [3] = '{7'd0, 7'd64, 7'd100};
    logic [63:0] exp_s [3] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    int lat;
    logic irs;
    for (int i = 0; i < 3; i++) begin
      run_to_hold(vals[i], lat, irs);
      checks++;
      if (lat !== 64) begin
        errors++;
        $display("FAIL extreme_latency v=%0d: got %0d want 64", vals[i], lat);
      end
      checks++;
      if (irs !== 1'b0) begin
        errors++;
        $display("FAIL extreme_in_ready_busy v=%0d: in_ready seen high during GEN", vals[i]);
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (st[d] !== exp_s[i]) begin
          errors++;
          $display("FAIL extreme_stream dut%0d v=%0d: got %h want %h", d, vals[i], st[d], exp_s[i]);
        end
      end
      release_hold();
      checks++;
      if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || st[0] !== exp_s[i]) begin
        errors++;
        $display("FAIL extreme_retain v=%0d: in_ready=%b out_valid=%b stream=%h want 1 0 %h",
                 vals[i], ir[0], ov[0], st[0], exp_s[i]);
      end
    end
  endtask

  task automatic test_half();
    int lat;
    logic irs;
    logic [12:0] low;
    run_to_hold(7'd32, lat, irs);
    low = st[0][12:0];
    // SEED=1 thresholds: 0,1,2,4,8,16,33,3,6,12,24,49,34 -> bits 1111110111100
    checks++;
    if (low !== 13'h07BF || st[0][0] !== 1'b1 || st[0][1] !== 1'b1) begin
      errors++;
      $display("FAIL half_low_bits: got %h want 07bf", low);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ($countones(st[d]) !== 32) begin
        errors++;
        $display("FAIL half_popcount dut%0d: got %0d want 32", d, $countones(st[d]));
      end
      checks++;
      if (st[d] !== model_stream(7'd32, sd[d])) begin
        errors++;
        $display("FAIL half_model dut%0d: got %h want %h", d, st[d], model_stream(7'd32, sd[d]));
      end
    end
    release_hold();
  endtask

  task automatic test_sweep();
    int lat;
    logic irs;
    for (int v = 0; v <= 64; v++) begin
      run_to_hold(v[6:0], lat, irs);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ($countones(st[d]) !== v || ov[d] !== 1'b1) begin
          errors++;
          $display("FAIL sweep_popcount dut%0d v=%0d: got %0d valid=%b", d, v, $countones(st[d]), ov[d]);
        end
      end
      release_hold();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic irs;
    logic [63:0] held;
    run_to_hold(7'd45, lat, irs);
    held = st[0];
    checks++;
    if (held !== model_stream(7'd45, 6'h01)) begin
      errors++;
      $display("FAIL bp_stream: got %h want %h", held, model_stream(7'd45, 6'h01));
    end
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      in_value = 7'(c * 3);
      tick();
      checks++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || st[0] !== held) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: out_valid=%b in_ready=%b stream=%h want 1 0 %h",
                 c, ov[0], ir[0], st[0], held);
      end
    end
    in_valid = 1'b0;
    release_hold();
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", ir[0], ov[0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic irs;
    logic saw_valid;
    in_value = 7'd50; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || ir[d] !== 1'b1 || st[d] !== 64'h0) begin
        errors++;
        $display("FAIL midreset_outputs dut%0d: out_valid=%b in_ready=%b stream=%h want 0 1 0",
                 d, ov[d], ir[d], st[d]);
      end
    end
    saw_valid = 1'b0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (ov[0] !== 1'b0) saw_valid = 1'b1;
    end
    out_ready = 1'b0;
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_valid: got out_valid pulse want none");
    end
    run_to_hold(7'd17, lat, irs);
    checks++;
    if (lat !== 64 || st[0] !== model_stream(7'd17, 6'h01)) begin
      errors++;
      $display("FAIL midreset_recover: lat=%0d stream=%h want 64 %h", lat, st[0], model_stream(7'd17, 6'h01));
    end
    release_hold();
  endtask

  task automatic test_back_to_back();
    logic [6:0] vals [3] = '{7'd10, 7'd64, 7'd33};
    int acc [3];
    int na = 0;
    int nv = 0;
    int cyc = 0;
    logic pre;
    in_value = vals[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (cyc < 300 && nv < 3) begin
      pre = ir[0] & in_valid;
      tick();
      cyc++;
      if (pre) begin
        acc[na] = cyc;
        na++;
        if (na < 3) in_value = vals[na];
        else in_valid = 1'b0;
      end
      if (ov[0] === 1'b1) begin
        checks++;
        if ($countones(st[1]) !== vals[nv] || st[0] !== model_stream(vals[nv], 6'h01)) begin
          errors++;
          $display("FAIL b2b_stream%0d: popcount=%0d stream=%h want %0d %h", nv,
                   $countones(st[1]), st[0], vals[nv], model_stream(vals[nv], 6'h01));
        end
        checks++;
        if (cyc - acc[nv] !== 64) begin
          errors++;
          $display("FAIL b2b_latency%0d: got %0d want 64", nv, cyc - acc[nv]);
        end
        nv++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (nv !== 3 || na !== 3) begin
      errors++;
      $display("FAIL b2b_count: streams=%0d accepts=%0d want 3 3", nv, na);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc[i] - acc[i-1] !== 66) begin
          errors++;
          $display("FAIL b2b_spacing%0d: got %0d want 66", i, acc[i] - acc[i-1]);
        end
      end
    end
    tick();
  endtask

  initial begin
    sd[0] = 6'h01; sd[1] = 6'h2A; sd[2] = 6'h00;
    rst_n = 1'b0; in_valid = 1'b0; in_value = 7'd0; out_ready = 1'b0;
    test_reset();
    test_extremes();
    test_half();
    test_sweep();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_stream_encoder.md
SC_STREAM_ENCODER -- requirements
Module: sc_stream_encoder

Interface
REQ-001 SHALL have parameter SEED, default 6'h01, meaning the initial 6-bit LFSR state loaded at each accepted transaction; the value 0 is illegal and SHALL be replaced by 6'h01.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  binary operand present.
REQ-005 SHALL have port in_value  input  7  unipolar probability numerator over 64 (0..64; 65..127 clamp to 64).
REQ-006 SHALL have port in_ready  output  1  encoder can accept an operand.
REQ-007 SHALL have port out_valid  output  1  out_stream holds a complete 64-bit stochastic stream.
REQ-008 SHALL have port out_stream  output  64  packed bitstream; bit[0] is generated first, bit[63] last.
REQ-009 SHALL have port out_ready  input  1  consumer takes out_stream.

Function
REQ-010 SHALL implement FSM states IDLE, GEN, HOLD.
REQ-011 In IDLE: in_ready=1, out_valid=0; on in_valid=1 SHALL latch clamped value, load count=0, load lfsr=SEED, clear out_stream to 0, go to GEN.
REQ-012 In GEN: in_ready=0, out_valid=0; each cycle SHALL write out_stream[count] = (r < value), with r = 0 when count==0, else r = current lfsr.
REQ-013 LFSR SHALL advance only on GEN cycles with count>=1: next = {lfsr[4:0], lfsr[5]^lfsr[4]} (x^6+x^5+1, period 63).
REQ-014 count SHALL be 6 bits and increment each GEN cycle; after the cycle writing bit 63 (count==63) FSM SHALL go to HOLD, count wraps to 0.
REQ-015 Comparison SHALL be 7-bit unsigned (r zero-extended); popcount(out_stream) SHALL equal clamped value exactly for every value and SEED.
REQ-016 In HOLD: out_valid=1, in_ready=0, out_stream stable; on out_ready=1 SHALL go to IDLE next cycle.
REQ-017 Latency: operand accepted on edge E -> out_valid=1 after edge E+64; out_valid asserts only in HOLD.
REQ-018 Throughput: one stream per 66 cycles minimum (accept, 64 GEN, HOLD with out_ready=1); in_ready is never 1 in GEN or HOLD.
REQ-019 in_valid/in_value changes during GEN or HOLD SHALL be ignored; latched value governs the whole stream.
REQ-020 out_ready outside HOLD SHALL have no effect.
REQ-021 out_stream SHALL retain the last completed stream in IDLE until the next acceptance clears it.

Reset
REQ-022 On rst_n=0 at a clock edge: state=IDLE, count=0, lfsr=SEED, latched value=0, out_stream=64'h0, out_valid=0; in_ready=1 from the first cycle after reset release.
REQ-023 Reset asserted mid-GEN or in HOLD SHALL abandon the stream with no out_valid pulse; no partial stream is ever presented.
REQ-024 in_valid sampled in the reset cycle SHALL not be accepted.

Verification
REQ-025 Reset then idle: out_stream=0, out_valid=0, in_ready=1; held for 10 cycles.
REQ-026 in_value=0 -> out_stream=64'h0; in_value=64 -> 64'hFFFF_FFFF_FFFF_FFFF; in_value=100 -> all ones (clamp); out_valid exactly 64 edges after acceptance.
REQ-027 in_value=32, SEED=1 -> popcount 32, bit[0]=1, bit[1]=1 (r=1), bit sequence matches LFSR reference model; repeat SEED=6'h2A, popcount still 32; sweep 0..64 popcount==value.
REQ-028 Backpressure: out_ready=0 for 20 cycles in HOLD -> out_valid=1, out_stream constant, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-029 rst_n=0 at count==40 of GEN -> next cycle all outputs at reset values, no out_valid; new operand afterwards produces correct full stream.
REQ-030 Back-to-back: in_valid held high with out_ready=1 -> successive streams 66 cycles apart, each popcount equal to its latched value.
